// File: rtl/ram_mover_pkg.sv
// Shared encodings for the RAM block mover: FSM state values and transfer modes.
package ram_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_block_mover.sv
// Small DMA engine for ram8: block COPY (src range to dst range) or block FILL
// (constant to dst range), one word per RAM access, ascending addresses.
module ram_block_mover
    import ram_mover_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                mode_q, mode_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        fill_d  = fill_q;
        mode_d  = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = count;
                    mode_d = mode;
                    fill_d = fill_value;
                    if (count == '0)
                        state_d = ST_DONE;
                    else if (mode == MODE_COPY)
                        state_d = ST_READ;
                    else
                        state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                data_d  = mem_out;
                src_d   = src_q + PTR_STEP;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                dst_d = dst_q + PTR_STEP;
                rem_d = rem_q - REM_ONE;
                if (rem_q == REM_ONE)
                    state_d = ST_DONE;
                else if (mode_q == MODE_COPY)
                    state_d = ST_READ;
                else
                    state_d = ST_WRITE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register alone, so reset silences the RAM port at once.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;

        unique case (state_q)
            ST_READ: begin
                busy        = 1'b1;
                mem_address = src_q;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_load    = 1'b1;
                mem_address = dst_q;
                mem_in      = (mode_q == MODE_FILL) ? fill_q : data_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            mode_q  <= MODE_COPY;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench for ram_block_mover driving a behavioural 8x16 RAM; a word-level
// reference model predicts every write, its cycle, and the done pulse.
module tb_ram_block_mover;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [2:0]  src_addr;
    logic [2:0]  dst_addr;
    logic [3:0]  count;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [2:0]  mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;

    ram_block_mover #(.ADDR_W(3), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .count       (count),
        .fill_value  (fill_value),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
    );

    // ram8 behaviour: combinational read, posedge write; a side port preloads words.
    logic [15:0] ram [8];
    logic        pre_we;
    logic [2:0]  pre_a;
    logic [15:0] pre_d;

    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_a] <= pre_d;
        else if (mem_load)
            ram[mem_address] <= mem_in;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t         sb [$];
    logic [15:0] ref_mem [8];
    int          pass_cnt   = 0;
    int          total_cnt  = 0;
    int          busy_total = 0;
    int          done_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every write or done pulse must match the oldest predicted event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_total++;
                if (done) done_total++;
                if (mem_load || done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", {30'd0, done, mem_load}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind", {30'd0, done, mem_load}, e.is_done ? 32'd2 : 32'd1);
                        check("event_cycle", cyc, e.cyc);
                        if (!e.is_done) begin
                            check("write_addr", {29'd0, mem_address}, {29'd0, e.addr});
                            check("write_data", {16'd0, mem_in}, {16'd0, e.data});
                        end
                    end
                end
            end
        end
    end

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 8; i++)
            check($sformatf("mem[%0d]", i), {16'd0, ram[i]}, {16'd0, ref_mem[i]});
    endtask

    // Predict a whole transfer from the word-level rules, then issue it and wait for done.
    task automatic run_op(input logic m, input logic [2:0] s, input logic [2:0] d,
                          input logic [3:0] n, input logic [15:0] f, input bit extra_start);
        int          c0, b0, d0, waited, exp_busy;
        logic [2:0]  as, ad;
        logic [15:0] v;
        @(posedge clk); #1;
        c0 = cyc + 1;
        for (int i = 0; i < int'(n); i++) begin
            as = s + 3'(i);
            ad = d + 3'(i);
            if (m == 1'b0) begin
                v = ref_mem[as];
                ref_mem[ad] = v;
                sb.push_back('{is_done: 1'b0, addr: ad, data: v, cyc: c0 + 2 * i + 1});
            end else begin
                ref_mem[ad] = f;
                sb.push_back('{is_done: 1'b0, addr: ad, data: f, cyc: c0 + i});
            end
        end
        exp_busy = (m == 1'b0) ? 2 * int'(n) : int'(n);
        sb.push_back('{is_done: 1'b1, addr: 3'd0, data: 16'd0, cyc: c0 + exp_busy});
        b0 = busy_total;
        d0 = done_total;
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        count      = n;
        fill_value = f;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        mode       = 1'($urandom);
        src_addr   = 3'($urandom);
        dst_addr   = 3'($urandom);
        count      = 4'($urandom);
        fill_value = 16'($urandom);
        if (extra_start) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waited = 0;
        while (done_total == d0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check("op_completed", {31'd0, done_total != d0}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("busy_cycles", busy_total - b0, exp_busy);
        check("done_pulses", done_total - d0, 32'd1);
        check("sb_drained", sb.size(), 32'd0);
        check_mem();
    endtask

    initial begin
        int d0;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        count      = '0;
        fill_value = '0;
        pre_we     = 1'b0;
        pre_a      = '0;
        pre_d      = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_load", {31'd0, mem_load}, 32'd0);
        check("rst_addr", {29'd0, mem_address}, 32'd0);
        check("rst_in", {16'd0, mem_in}, 32'd0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

        run_op(1'b1, 3'd0, 3'd2, 4'd3, 16'hABAB, 1'b0);

        preload(3'd0, 16'h1111);
        preload(3'd1, 16'h2222);
        preload(3'd2, 16'h3333);
        preload(3'd3, 16'h4444);
        run_op(1'b0, 3'd0, 3'd4, 4'd4, 16'h0000, 1'b0);

        preload(3'd6, 16'hAAAA);
        preload(3'd7, 16'hBBBB);
        preload(3'd0, 16'hCCCC);
        run_op(1'b0, 3'd6, 3'd1, 4'd3, 16'h0000, 1'b0);

        run_op(1'b0, 3'd3, 3'd5, 4'd0, 16'h1234, 1'b0);
        run_op(1'b1, 3'd3, 3'd5, 4'd0, 16'h1234, 1'b0);

        run_op(1'b1, 3'd1, 3'd6, 4'd5, 16'h5A5A, 1'b1);

        // Abort a FILL during its second write: only the first word lands.
        for (int i = 0; i < 8; i++) preload(3'(i), 16'h0101 * 16'(i + 1));
        @(posedge clk); #1;
        sb.push_back('{is_done: 1'b0, addr: 3'd0, data: 16'hCDCD, cyc: cyc + 1});
        sb.push_back('{is_done: 1'b0, addr: 3'd1, data: 16'hCDCD, cyc: cyc + 2});
        ref_mem[0] = 16'hCDCD;
        d0         = done_total;
        mode       = 1'b1;
        dst_addr   = 3'd0;
        count      = 4'd4;
        fill_value = 16'hCDCD;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_load", {31'd0, mem_load}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_addr", {29'd0, mem_address}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("abort_no_done", done_total - d0, 32'd0);
        check("abort_sb_drained", sb.size(), 32'd0);
        check_mem();
        run_op(1'b1, 3'd0, 3'd2, 4'd2, 16'hBEEF, 1'b0);

        for (int k = 0; k < 24; k++)
            run_op(1'($urandom), 3'($urandom), 3'($urandom), 4'($urandom_range(0, 15)),
                   16'($urandom), $urandom_range(0, 3) == 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
